// File: rtl/mips_pkg.sv
// mips_pkg: opcode/funct constants, control encodings, FSM states and decode types for mc_controller
package mips_pkg;
   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_ORI   = 6'h0d;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2b;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_LUI   = 6'h0f;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_JAL   = 6'h03;
   localparam logic [5:0] FN_ADDU  = 6'h21;
   localparam logic [5:0] FN_SUBU  = 6'h23;
   localparam logic [5:0] FN_JR    = 6'h08;
   localparam logic [1:0] NPC_SEL_PC_ADD_4 = 2'b00;
   localparam logic [1:0] NPC_SEL_REG_JMP  = 2'b01;
   localparam logic [1:0] NPC_SEL_J_JMP    = 2'b10;
   localparam logic [1:0] NPC_SEL_BEQ_JMP  = 2'b11;
   localparam logic [2:0] ALU_OP_ADD = 3'b000;
   localparam logic [2:0] ALU_OP_SUB = 3'b001;
   localparam logic [2:0] ALU_OP_OR  = 3'b010;
   localparam logic [2:0] ALU_OP_LUI = 3'b011;
   localparam logic [1:0] EXT_OP_ZERO = 2'b00;
   localparam logic [1:0] EXT_OP_SIGN = 2'b01;
   localparam logic [1:0] EXT_OP_LUI  = 2'b10;
   localparam logic [1:0] REG_DST_RT = 2'b00;
   localparam logic [1:0] REG_DST_RD = 2'b01;
   localparam logic [1:0] REG_DST_RA = 2'b10;
   localparam logic [1:0] MEM_TO_REG_ALU = 2'b00;
   localparam logic [1:0] MEM_TO_REG_DM  = 2'b01;
   localparam logic [1:0] MEM_TO_REG_PC4 = 2'b10;
   typedef enum logic [2:0] {
      ST_FETCH  = 3'd0,
      ST_DECODE = 3'd1,
      ST_EXEC   = 3'd2,
      ST_MEM    = 3'd3,
      ST_WB     = 3'd4
   } state_e;
   typedef enum logic [3:0] {
      CL_NOP, CL_ILL, CL_ALU, CL_LW, CL_SW, CL_BEQ, CL_J, CL_JAL, CL_JR
   } iclass_e;
   typedef struct packed {
      logic [1:0] reg_dst;
      logic [1:0] mem_to_reg;
      logic [2:0] alu_op;
      logic       alu_src;
      logic [1:0] ext_op;
   } ctrl_t;
endpackage

// File: rtl/mc_decode.sv
// mc_decode: combinational IR -> instruction class plus static datapath controls
//  ir_i   in  32  latched instruction register
//  cls_o  out     instruction class (drives state sequencing)
//  ctrl_o out     reg_dst/mem_to_reg/alu_op/alu_src/ext_op, constant for the whole instruction
module mc_decode
   import mips_pkg::*;
(
   input  logic [31:0] ir_i,
   output iclass_e     cls_o,
   output ctrl_t       ctrl_o
);
   logic [5:0] op, fn;
   assign op = ir_i[31:26];
   assign fn = ir_i[5:0];
   always_comb begin
      cls_o  = CL_ILL;
      ctrl_o = '0;
      case (op)
         OP_RTYPE: begin
            if (fn == FN_ADDU || fn == FN_SUBU) begin
               cls_o          = CL_ALU;
               ctrl_o.reg_dst = REG_DST_RD;
               ctrl_o.alu_op  = fn == FN_SUBU ? ALU_OP_SUB : ALU_OP_ADD;
            end else if (fn == FN_JR) cls_o = CL_JR;
            else if (ir_i == '0) cls_o = CL_NOP;
         end
         OP_ORI: begin
            cls_o          = CL_ALU;
            ctrl_o.alu_src = 1'b1;
            ctrl_o.alu_op  = ALU_OP_OR;
            ctrl_o.ext_op  = EXT_OP_ZERO;
         end
         OP_LUI: begin
            cls_o          = CL_ALU;
            ctrl_o.alu_src = 1'b1;
            ctrl_o.alu_op  = ALU_OP_LUI;
            ctrl_o.ext_op  = EXT_OP_LUI;
         end
         OP_LW: begin
            cls_o             = CL_LW;
            ctrl_o.alu_src    = 1'b1;
            ctrl_o.ext_op     = EXT_OP_SIGN;
            ctrl_o.mem_to_reg = MEM_TO_REG_DM;
         end
         OP_SW: begin
            cls_o          = CL_SW;
            ctrl_o.alu_src = 1'b1;
            ctrl_o.ext_op  = EXT_OP_SIGN;
         end
         OP_BEQ: begin
            cls_o         = CL_BEQ;
            ctrl_o.alu_op = ALU_OP_SUB;
            ctrl_o.ext_op = EXT_OP_SIGN;
         end
         OP_J:   cls_o = CL_J;
         OP_JAL: begin
            cls_o             = CL_JAL;
            ctrl_o.reg_dst    = REG_DST_RA;
            ctrl_o.mem_to_reg = MEM_TO_REG_PC4;
         end
         default: ;
      endcase
   end
endmodule

// File: rtl/mc_controller.sv
// mc_controller: multi-cycle FETCH/DECODE/EXEC/MEM/WB control FSM with internal IR
//  clk, reset (async, active-low); instruction[31:0] from IFU; zero from ALU (used only in beq EXEC)
//  ir_we, pc_we, NPCSel[1:0] to IFU; reg_we, reg_dst, alu_src, alu_op, ext_op, mem_we, mem_to_reg to datapath
//  illegal: one-cycle pulse in DECODE for unsupported encodings; state[2:0]: current FSM state
//  MC_CTRL_PERF_EN: adds cycle_cnt/instret_cnt[CNT_W-1:0] performance counters
module mc_controller
   import mips_pkg::*;
#(
   parameter int RA_REG = 31
`ifdef MC_CTRL_PERF_EN
   , parameter int CNT_W = 32
`endif
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] instruction,
   input  logic        zero,
   output logic        ir_we,
   output logic        pc_we,
   output logic [1:0]  NPCSel,
   output logic        reg_we,
   output logic [1:0]  reg_dst,
   output logic        alu_src,
   output logic [2:0]  alu_op,
   output logic [1:0]  ext_op,
   output logic        mem_we,
   output logic [1:0]  mem_to_reg,
   output logic        illegal,
   output logic [2:0]  state
`ifdef MC_CTRL_PERF_EN
   , output logic [CNT_W-1:0] cycle_cnt
   , output logic [CNT_W-1:0] instret_cnt
`endif
);
   state_e      state_q, state_d;
   logic [31:0] ir_q;
   iclass_e     cls;
   ctrl_t       ctrl;
   logic        fin, reg_wr, mem_wr, ill;
   logic [1:0]  npc;
   // reg_dst=RA_REG only names the link register; the index itself is muxed in downstream
   if (RA_REG != 31) begin : g_ra_custom
   end
   mc_decode u_decode (
      .ir_i   (ir_q),
      .cls_o  (cls),
      .ctrl_o (ctrl)
   );
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= ST_FETCH;
         ir_q    <= '0;
      end else begin
         state_q <= state_d;
         if (ir_we) ir_q <= instruction;
      end
   end
   // fin marks the last state of an instruction: it owns the single pc_we pulse
   always_comb begin
      state_d = ST_FETCH;
      fin     = 1'b0;
      reg_wr  = 1'b0;
      mem_wr  = 1'b0;
      ill     = 1'b0;
      npc     = NPC_SEL_PC_ADD_4;
      case (state_q)
         ST_FETCH: state_d = ST_DECODE;
         ST_DECODE: begin
            if (cls inside {CL_ALU, CL_LW, CL_SW, CL_BEQ}) state_d = ST_EXEC;
            else begin
               fin    = 1'b1;
               reg_wr = cls == CL_JAL;
               ill    = cls == CL_ILL;
               npc    = cls == CL_JR ? NPC_SEL_REG_JMP :
                        (cls == CL_J || cls == CL_JAL) ? NPC_SEL_J_JMP : NPC_SEL_PC_ADD_4;
            end
         end
         ST_EXEC: begin
            if (cls == CL_BEQ) begin
               fin = 1'b1;
               npc = zero ? NPC_SEL_BEQ_JMP : NPC_SEL_PC_ADD_4;
            end else state_d = cls == CL_ALU ? ST_WB : ST_MEM;
         end
         ST_MEM: begin
            if (cls == CL_SW) begin
               fin    = 1'b1;
               mem_wr = 1'b1;
            end else state_d = ST_WB;
         end
         ST_WB: begin
            fin    = 1'b1;
            reg_wr = 1'b1;
         end
         default: ;
      endcase
   end
   // strobes are qualified with reset so nothing writes while reset is held low
   assign ir_we      = reset & (state_q == ST_FETCH);
   assign pc_we      = reset & fin;
   assign reg_we     = reset & reg_wr;
   assign mem_we     = reset & mem_wr;
   assign NPCSel     = npc;
   assign illegal    = ill;
   assign reg_dst    = ctrl.reg_dst;
   assign mem_to_reg = ctrl.mem_to_reg;
   assign alu_op     = ctrl.alu_op;
   assign alu_src    = ctrl.alu_src;
   assign ext_op     = ctrl.ext_op;
   assign state      = state_q;
`ifdef MC_CTRL_PERF_EN
   logic [CNT_W-1:0] cycle_q, instret_q;
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cycle_q   <= '0;
         instret_q <= '0;
      end else begin
         cycle_q <= cycle_q + CNT_W'(1);
         if (pc_we) instret_q <= instret_q + CNT_W'(1);
      end
   end
   assign cycle_cnt   = cycle_q;
   assign instret_cnt = instret_q;
`endif
endmodule

// File: tb/tb_mc_controller.sv
// tb_mc_controller: table-driven directed checks of mc_controller sequencing and controls
module tb_mc_controller;
   logic        clk = 1'b0, reset = 1'b1, zero = 1'b0;
   logic [31:0] instruction = '0;
   logic        ir_we, pc_we, reg_we, alu_src, mem_we, illegal;
   logic [1:0]  NPCSel, reg_dst, ext_op, mem_to_reg;
   logic [2:0]  alu_op, state;
`ifdef MC_CTRL_PERF_EN
   logic [31:0] cycle_cnt, instret_cnt;
   logic [31:0] ir_before;
`endif
   int tests = 0, fails = 0;
   always #5 clk = ~clk;
   mc_controller dut (
      .clk         (clk),
      .reset       (reset),
      .instruction (instruction),
      .zero        (zero),
      .ir_we       (ir_we),
      .pc_we       (pc_we),
      .NPCSel      (NPCSel),
      .reg_we      (reg_we),
      .reg_dst     (reg_dst),
      .alu_src     (alu_src),
      .alu_op      (alu_op),
      .ext_op      (ext_op),
      .mem_we      (mem_we),
      .mem_to_reg  (mem_to_reg),
      .illegal     (illegal),
      .state       (state)
`ifdef MC_CTRL_PERF_EN
      , .cycle_cnt   (cycle_cnt)
      , .instret_cnt (instret_cnt)
`endif
   );
   typedef struct {
      string       name;
      logic [31:0] instr;
      logic        z;
      int          cyc;
      logic [1:0]  npc;
      logic        rwe;
      logic        mwe;
      logic [9:0]  ctrl;
      logic        ill;
   } vec_t;
   vec_t vecs[$];
   task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", n, act, exp);
      end
   endtask
   task automatic run(input vec_t v);
      int  c = 0, ills = 0, rwes = 0, mwes = 0;
      bit  done = 1'b0;
      chk({v.name, " start_state"}, 32'(state), 0);
      instruction = v.instr;
      zero = v.z;
      for (int i = 1; i <= 8 && !done; i++) begin
         if (state != 3'd0)
            chk({v.name, " ctrl"}, 32'({reg_dst, mem_to_reg, alu_op, alu_src, ext_op}), 32'(v.ctrl));
         ills += int'(illegal);
         rwes += int'(reg_we);
         mwes += int'(mem_we);
         if (pc_we) begin
            done = 1'b1;
            c = i;
            chk({v.name, " NPCSel"}, 32'(NPCSel), 32'(v.npc));
         end else begin
            @(posedge clk);
            #1;
         end
      end
      chk({v.name, " cycles"}, c, v.cyc);
      chk({v.name, " illegal_pulses"}, ills, int'(v.ill));
      chk({v.name, " reg_we_pulses"}, rwes, int'(v.rwe));
      chk({v.name, " mem_we_pulses"}, mwes, int'(v.mwe));
      @(posedge clk);
      #1;
      chk({v.name, " back_to_fetch"}, 32'(state), 0);
   endtask
   // ctrl = {reg_dst[1:0], mem_to_reg[1:0], alu_op[2:0], alu_src, ext_op[1:0]}
   initial begin
      vecs.push_back('{"addu",  32'h00221821, 1'b1, 4, 2'b00, 1'b1, 1'b0, 10'b01_00_000_0_00, 1'b0});
      vecs.push_back('{"subu",  32'h00221823, 1'b0, 4, 2'b00, 1'b1, 1'b0, 10'b01_00_001_0_00, 1'b0});
      vecs.push_back('{"ori",   32'h3422ffff, 1'b0, 4, 2'b00, 1'b1, 1'b0, 10'b00_00_010_1_00, 1'b0});
      vecs.push_back('{"lui",   32'h3c011234, 1'b0, 4, 2'b00, 1'b1, 1'b0, 10'b00_00_011_1_10, 1'b0});
      vecs.push_back('{"lw",    32'h8c220004, 1'b0, 5, 2'b00, 1'b1, 1'b0, 10'b00_01_000_1_01, 1'b0});
      vecs.push_back('{"sw",    32'hac220004, 1'b1, 4, 2'b00, 1'b0, 1'b1, 10'b00_00_000_1_01, 1'b0});
      vecs.push_back('{"beq_t", 32'h10220003, 1'b1, 3, 2'b11, 1'b0, 1'b0, 10'b00_00_001_0_01, 1'b0});
      vecs.push_back('{"beq_n", 32'h10220003, 1'b0, 3, 2'b00, 1'b0, 1'b0, 10'b00_00_001_0_01, 1'b0});
      vecs.push_back('{"j",     32'h08000010, 1'b1, 2, 2'b10, 1'b0, 1'b0, 10'b00_00_000_0_00, 1'b0});
      vecs.push_back('{"jal",   32'h0c000042, 1'b0, 2, 2'b10, 1'b1, 1'b0, 10'b10_10_000_0_00, 1'b0});
      vecs.push_back('{"jr",    32'h03e00008, 1'b0, 2, 2'b01, 1'b0, 1'b0, 10'b00_00_000_0_00, 1'b0});
      vecs.push_back('{"illop", 32'hfc000000, 1'b0, 2, 2'b00, 1'b0, 1'b0, 10'b00_00_000_0_00, 1'b1});
      vecs.push_back('{"nop",   32'h00000000, 1'b0, 2, 2'b00, 1'b0, 1'b0, 10'b00_00_000_0_00, 1'b0});
      vecs.push_back('{"badfn", 32'h00000001, 1'b0, 2, 2'b00, 1'b0, 1'b0, 10'b00_00_000_0_00, 1'b1});
      // power-on reset: every output low while reset is held
      #2 reset = 1'b0;
      @(posedge clk);
      #1;
      chk("reset outputs", 32'({ir_we, pc_we, NPCSel, reg_we, reg_dst, alu_src, alu_op, ext_op,
                                mem_we, mem_to_reg, illegal, state}), 0);
      reset = 1'b1;
      #1;
      chk("release ir_we", 32'(ir_we), 1);
      foreach (vecs[k]) run(vecs[k]);
      // reset asserted in the middle of lw EXEC
      instruction = 32'h8c220004;
      @(posedge clk);
      #1;
      @(posedge clk);
      #1;
      chk("lw reached EXEC", 32'(state), 2);
      reset = 1'b0;
      @(posedge clk);
      #1;
      chk("midreset state", 32'(state), 0);
      chk("midreset strobes", 32'({reg_we, mem_we, pc_we, ir_we}), 0);
      @(posedge clk);
      #1;
      chk("midreset hold strobes", 32'({reg_we, mem_we, pc_we, illegal}), 0);
      reset = 1'b1;
      #1;
      chk("midreset release state", 32'(state), 0);
      chk("midreset release ir_we", 32'(ir_we), 1);
      run(vecs[0]);
`ifdef MC_CTRL_PERF_EN
      ir_before = instret_cnt;
      run(vecs[11]);
      chk("instret after illegal", instret_cnt, ir_before + 32'd1);
`endif
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
